// File: rtl/rv32_mem_stage.sv
// -----------------------------------------------------------------------------
// rv32_mem_stage
//   Memory stage of the RV32 pipeline. Takes the exec buffer, drives the data
//   bus for loads and stores and registers the result into the mem buffer,
//   which writeback reads and which feeds the exec-stage bypass.
//   Store data is replicated across byte lanes. Load data is taken from the
//   lane selected by the address and then sign- or zero-extended. While a bus
//   transaction is outstanding the stage asks hazard control to freeze.
//
// Ports
//   clk              clock
//   resetn           synchronous active-low reset
//   exec_data        exec buffer: instr, pc, decoded_instr, mem_addr, wb_result
//   mem_data         registered mem buffer: instr, pc, decoded_instr, wb_result
//   stop             downstream freeze; mem_data holds while high
//   stall_req        freeze request; the exec buffer holds while high
//   dbus_req_valid   bus request valid
//   dbus_req_ready   bus request accepted when valid & ready
//   dbus_addr        word-aligned bus address
//   dbus_we          1 = store
//   dbus_be          byte enables
//   dbus_wdata       store data replicated across lanes
//   dbus_rsp_valid   load response valid
//   dbus_rdata       load response word
//   misaligned_fault one-cycle pulse, aligned with the faulting instr in mem_data
//   bus_error        one-cycle pulse, aligned with the timed-out load in mem_data
// -----------------------------------------------------------------------------

package rv32_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_we;
        mem_op_t    mem_op;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    mem_addr;
        logic [31:0]    wb_result;
    } exec_buffer_data_t;

    typedef struct packed {
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t decoded_instr;
        logic [31:0]    wb_result;
    } mem_buffer_data_t;

    function automatic decoded_instr_t create_nop_ctrl();
        decoded_instr_t ctrl;
        ctrl.rd     = 5'd0;
        ctrl.rd_we  = 1'b0;
        ctrl.mem_op = MEM_NONE;
        return ctrl;
    endfunction

    function automatic mem_buffer_data_t create_nop_mem();
        mem_buffer_data_t m;
        m.instr         = RV_NOP;
        m.pc            = 32'h0;
        m.decoded_instr = create_nop_ctrl();
        m.wb_result     = 32'h0;
        return m;
    endfunction

endpackage

// State table
//   state    | meaning
//   IDLE     | no transaction; pass-through, misaligned faults, new requests
//   REQ      | request presented, waiting for dbus_req_ready
//   WAIT_RSP | load accepted, waiting for dbus_rsp_valid or timeout
//   HOLD     | result parked in pending while stop is high; released when stop falls
module rv32_mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  exec_buffer_data_t exec_data,
    output mem_buffer_data_t  mem_data,
    input  logic              stop,
    output logic              stall_req,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic [31:0]       dbus_addr,
    output logic              dbus_we,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_rsp_valid,
    input  logic [31:0]       dbus_rdata,
    output logic              misaligned_fault,
    output logic              bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_HOLD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  wait_cnt;
    mem_buffer_data_t  pending;
    logic              pending_err;

    mem_op_t           mem_op;
    logic [1:0]        lane;
    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              is_half;
    logic              is_word;
    logic              misaligned;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic [31:0]       rdata_shifted;

    logic              req_valid;
    logic              commit;
    logic              park;
    logic              release_hold;
    logic              rsp_done;
    logic              res_fault;
    logic              res_err;
    mem_buffer_data_t  result_d;

    // ---------------------------------------------------------------- decode
    assign mem_op = exec_data.decoded_instr.mem_op;
    assign lane   = exec_data.mem_addr[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_op)
            MEM_LB, MEM_LBU: is_load = 1'b1;
            MEM_LH, MEM_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            MEM_LW:          begin is_load = 1'b1; is_word = 1'b1; end
            MEM_SB:          is_store = 1'b1;
            MEM_SH:          begin is_store = 1'b1; is_half = 1'b1; end
            MEM_SW:          begin is_store = 1'b1; is_word = 1'b1; end
            default:         ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));

    always_comb begin
        if (is_word) begin
            lane_be    = 4'b1111;
            lane_wdata = exec_data.wb_result;
        end else if (is_half) begin
            lane_be    = lane[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{exec_data.wb_result[15:0]}};
        end else begin
            lane_be    = 4'b0001 << lane;
            lane_wdata = {4{exec_data.wb_result[7:0]}};
        end
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign rdata_shifted = dbus_rdata >> {lane, 3'b000};

    always_comb begin
        case (mem_op)
            MEM_LB:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            MEM_LBU: load_data = {24'h0, rdata_shifted[7:0]};
            MEM_LH:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            MEM_LHU: load_data = {16'h0, rdata_shifted[15:0]};
            default: load_data = dbus_rdata;
        endcase
    end

    // ---------------------------------------------------------------- bus
    assign dbus_req_valid = req_valid;
    assign dbus_addr      = req_valid ? {exec_data.mem_addr[31:2], 2'b00} : 32'h0;
    assign dbus_we        = req_valid & is_store;
    assign dbus_be        = req_valid ? lane_be : 4'b0000;
    assign dbus_wdata     = (req_valid && is_store) ? lane_wdata : 32'h0;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        req_valid             = 1'b0;
        stall_req             = 1'b0;
        commit                = 1'b0;
        park                  = 1'b0;
        release_hold          = 1'b0;
        rsp_done              = 1'b0;
        res_fault             = 1'b0;
        res_err               = 1'b0;
        result_d.instr         = exec_data.instr;
        result_d.pc            = exec_data.pc;
        result_d.decoded_instr = exec_data.decoded_instr;
        result_d.wb_result     = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (!stop) begin
                    if (!is_mem) begin
                        commit             = 1'b1;
                        result_d.wb_result = exec_data.wb_result;
                    end else if (misaligned) begin
                        commit    = 1'b1;
                        res_fault = 1'b1;
                    end else begin
                        req_valid = 1'b1;
                        if (!dbus_req_ready) begin
                            stall_req = 1'b1;
                            state_d   = S_REQ;
                        end else if (is_store) begin
                            commit = 1'b1;
                        end else begin
                            stall_req = 1'b1;
                            state_d   = S_WAIT_RSP;
                        end
                    end
                end
            end

            S_REQ: begin
                req_valid = 1'b1;
                stall_req = 1'b1;
                if (dbus_req_ready) begin
                    if (is_load) begin
                        state_d = S_WAIT_RSP;
                    end else if (stop) begin
                        park    = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        commit    = 1'b1;
                        stall_req = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_WAIT_RSP: begin
                stall_req = 1'b1;
                if (dbus_rsp_valid) begin
                    result_d.wb_result = load_data;
                    rsp_done           = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
                    res_err  = 1'b1;
                    rsp_done = 1'b1;
                end
                if (rsp_done) begin
                    if (stop) begin
                        park    = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        commit    = 1'b1;
                        stall_req = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_HOLD: begin
                stall_req = 1'b1;
                // Releasing the pending result is the completion cycle, so the
                // exec buffer must be allowed to advance at this same edge.
                if (!stop) begin
                    release_hold = 1'b1;
                    stall_req    = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath regs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt         <= '0;
            mem_data         <= create_nop_mem();
            pending          <= create_nop_mem();
            pending_err      <= 1'b0;
            misaligned_fault <= 1'b0;
            bus_error        <= 1'b0;
        end else begin
            if (state_q == S_WAIT_RSP) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            misaligned_fault <= 1'b0;
            bus_error        <= 1'b0;

            if (commit) begin
                mem_data         <= result_d;
                misaligned_fault <= res_fault;
                bus_error        <= res_err;
            end else if (release_hold) begin
                mem_data  <= pending;
                bus_error <= pending_err;
            end

            if (park) begin
                pending     <= result_d;
                pending_err <= res_err;
            end
        end
    end

endmodule
